// File: rtl/blackjack_pkg.sv
// ---------------------------------------------------------------------------
// blackjack_pkg
// Shared constants for the blackjack datapath: deck geometry, card encoding
// (code = suit*SUIT_SIZE + rank), LFSR parameters and the shuffler FSM states.
// The blackjack controller decodes cards with the same helpers, so the
// encoding must only change here.
// ---------------------------------------------------------------------------
package blackjack_pkg;

  localparam int DECK_SIZE = 52;
  localparam int CARD_W    = 6;   // ceil(log2(DECK_SIZE))
  localparam int SUIT_SIZE = 13;  // ranks per suit, Ace = 0 .. King = 12
  localparam int NUM_SUITS = 4;   // clubs, diamonds, hearts, spades

  localparam int                 LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  localparam logic [CARD_W-1:0] LAST_IDX = CARD_W'(DECK_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_STREAM,
    ST_DONE
  } shuf_state_e;

  // Smallest all-ones value (2^k-1) that is >= i. Used to fold the random
  // draw into a range no wider than twice the live window, keeping the
  // rejection rate below one half.
  function automatic logic [CARD_W-1:0] shuf_mask(input logic [CARD_W-1:0] i);
    logic [CARD_W-1:0] m;
    m = '0;
    for (int b = 0; b < CARD_W; b++) begin
      if (i > m) m = {m[CARD_W-2:0], 1'b1};
    end
    return m;
  endfunction

  // Card decode helpers shared with the controller.
  function automatic logic [2:0] card_suit(input logic [CARD_W-1:0] c);
    return 3'(c / CARD_W'(SUIT_SIZE));
  endfunction

  function automatic logic [3:0] card_rank(input logic [CARD_W-1:0] c);
    return 4'(c % CARD_W'(SUIT_SIZE));
  endfunction

endpackage

// File: rtl/card_shuffler_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR (taps LFSR_TAPS). Advances every cycle;
// a load overrides the advance for that cycle. A zero load value would lock
// the register at zero, so it is replaced by SEED.
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset, q -> SEED
//   load_i      load load_val_i this cycle instead of advancing
//   load_val_i  value to load (0 -> SEED)
//   q_o         current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
  import blackjack_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] load_val_i,
  output logic [LFSR_W-1:0] q_o
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = {1'b0, q_q[LFSR_W-1:1]} ^ (q_q[0] ? LFSR_TAPS : '0);
    if (load_i) q_d = (load_val_i == '0) ? SEED : load_val_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= SEED;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/card_shuffler.sv
// ---------------------------------------------------------------------------
// card_shuffler
// Builds a 52-card deck, Fisher-Yates shuffles it in place with an LFSR
// source, then streams it out one card per valid/ready beat, followed by a
// one-cycle done pulse. Feeds the blackjack controller's LOAD state.
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       level, sampled in IDLE only: build + shuffle + stream
//   seed_load_i   in IDLE, load seed_in_i into the LFSR (0 -> SEED)
//   seed_in_i     seed value
//   busy_o        high from the cycle after start is accepted until done
//   load_valid_o  card_o / card_index_o hold a valid beat
//   load_ready_i  consumer accepts the beat when valid && ready
//   card_o        shuffled card code (suit*13 + rank)
//   card_index_o  deck position of the beat, ascending 0..51
//   done_o        one-cycle pulse after the last beat is accepted
// ---------------------------------------------------------------------------
module card_shuffler
  import blackjack_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_in_i,
  output logic              busy_o,
  output logic              load_valid_o,
  input  logic              load_ready_i,
  output logic [CARD_W-1:0] card_o,
  output logic [CARD_W-1:0] card_index_o,
  output logic              done_o
);

  shuf_state_e       state_q, state_d;
  logic [CARD_W-1:0] i_q, i_d;   // build / shuffle position
  logic [CARD_W-1:0] k_q, k_d;   // stream position

  // Plain register array: the swap reads and writes two arbitrary entries
  // in one cycle, which a single-port RAM could not do.
  logic [CARD_W-1:0] deck_q [DECK_SIZE];

  logic [LFSR_W-1:0] lfsr;
  logic              seed_ld;
  logic [CARD_W-1:0] mask, r;
  logic              swap_ok;
  logic              unused_lfsr_hi;

  // Seed only lands while idle; it shares the cycle with an accepted start
  // so that shuffle runs from the fresh seed.
  assign seed_ld = (state_q == ST_IDLE) && seed_load_i;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (seed_ld),
    .load_val_i (seed_in_i),
    .q_o        (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:CARD_W];

  // Rejection sampling: a draw above i is discarded and retried next cycle
  // with the next LFSR value, which keeps the choice uniform over 0..i.
  assign mask    = shuf_mask(i_q);
  assign r       = lfsr[CARD_W-1:0] & mask;
  assign swap_ok = (r <= i_q);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_INIT;
          i_d     = '0;
        end
      end
      ST_INIT: begin
        if (i_q == LAST_IDX) begin
          state_d = ST_SHUFFLE;
          i_d     = LAST_IDX;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_SHUFFLE: begin
        if (swap_ok) begin
          if (i_q == CARD_W'(1)) begin
            state_d = ST_STREAM;
            k_d     = '0;
          end else begin
            i_d = i_q - 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (load_ready_i) begin
          if (k_q == LAST_IDX) begin
            state_d = ST_DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
    end
  end

  // -------------------------------------------------------------------------
  // Deck storage. Contents are don't-care after reset; INIT rewrites every
  // entry before the shuffle reads any of them. When r == i both writes
  // target the same entry with its own value, so the no-op swap is safe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      deck_q[i_q] <= i_q;
    end else if (state_q == ST_SHUFFLE && swap_ok) begin
      deck_q[i_q] <= deck_q[r];
      deck_q[r]   <= deck_q[i_q];
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decode straight from state so reset clears them asynchronously.
  // card_o is gated to zero outside STREAM so stale deck contents never leak.
  // -------------------------------------------------------------------------
  assign busy_o       = (state_q == ST_INIT) || (state_q == ST_SHUFFLE) ||
                        (state_q == ST_STREAM);
  assign load_valid_o = (state_q == ST_STREAM);
  assign done_o       = (state_q == ST_DONE);
  assign card_o       = load_valid_o ? deck_q[k_q] : '0;
  assign card_index_o = k_q;

endmodule
